// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    // Next decimal value of one digit; anything at or above 9 rolls to 0.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
        return (d >= BCD_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Button-command and display bundle between the stopwatch controller and its neighbours.
interface bcd_stopwatch_ctrl_if
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
);

    // Commands are single-cycle pulses with no back-pressure: a pulse is seen
    // exactly in the cycle it is high and is either acted on or dropped.
    logic                       start_stop;
    logic                       clear;
    logic                       lap;
    logic [BCD_W*NDIGITS-1:0]   digits;
    logic                       running;
    logic                       tick;
    logic                       overflow;
    state_t                     state;

    modport master (
        output start_stop,
        output clear,
        output lap,
        input  digits,
        input  running,
        input  tick,
        input  overflow,
        input  state
    );

    modport slave (
        input  start_stop,
        input  clear,
        input  lap,
        output digits,
        output running,
        output tick,
        output overflow,
        output state
    );

endinterface

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// One decimal digit of the cascaded counter; carry_out enables the next digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (en) begin
            digit_d = bcd_inc(digit_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = en && (digit_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch: prescaler, run-state FSM, BCD digit chain
// and a lap snapshot that freezes the display while counting continues.
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int NDIGITS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    bcd_stopwatch_ctrl_if.slave bus
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam int              CW         = BCD_W * NDIGITS;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    state_t          state_q;
    logic [PW-1:0]   presc_q;
    logic [CW-1:0]   snap_q;
    logic            ovf_q;

    logic [CW-1:0]   count;
    logic            run_active;
    logic            tick;
    logic            clear_acc;
    logic            wrap;

    assign run_active = (state_q == RUN) || (state_q == LAP);
    assign tick       = run_active && (presc_q == PRESC_LAST);
    // clear outranks everything but is only legal while paused.
    assign clear_acc  = (state_q == PAUSE) && bus.clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            snap_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (run_active) begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
            end
            if (wrap) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start_stop) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.start_stop) begin
                        state_q <= PAUSE;
                    end else if (bus.lap) begin
                        state_q <= LAP;
                        // Registered count is the pre-increment value even on a tick.
                        snap_q  <= count;
                    end
                end
                LAP: begin
                    if (bus.start_stop) begin
                        state_q <= PAUSE;
                    end else if (bus.lap) begin
                        state_q <= RUN;
                    end
                end
                PAUSE: begin
                    if (bus.clear) begin
                        state_q <= IDLE;
                        presc_q <= '0;
                        ovf_q   <= 1'b0;
                    end else if (bus.start_stop) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Each digit owns its enable/carry pair so the ripple stays a plain chain.
    for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
        logic en_k;
        logic carry_k;

        if (k == 0) begin : g_lsd
            assign en_k = tick;
        end else begin : g_upper
            assign en_k = g_digit[k-1].carry_k;
        end

        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .en        (en_k),
            .clr       (clear_acc),
            .digit     (count[k*BCD_W +: BCD_W]),
            .carry_out (carry_k)
        );
    end

    assign wrap = g_digit[NDIGITS-1].carry_k;

    assign bus.digits   = (state_q == LAP) ? snap_q : count;
    assign bus.running  = run_active;
    assign bus.tick     = tick;
    assign bus.overflow = ovf_q;
    assign bus.state    = state_q;

endmodule
